// File: rtl/myproject_mul_acc_pipe.sv
// Pipelined multiply-accumulate: operand products flow through NUM_STAGE registers into a
// saturating or wrapping group accumulator, with a single-entry result register and backpressure.
module myproject_mul_acc_pipe #(
  parameter int unsigned DIN0_WIDTH  = 8,
  parameter int unsigned DIN1_WIDTH  = 11,
  parameter int unsigned DIN0_SIGNED = 0,
  parameter int unsigned DIN1_SIGNED = 1,
  parameter int unsigned NUM_STAGE   = 2,
  parameter int unsigned ACC_WIDTH   = 24,
  parameter int unsigned SATURATE    = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  dout,
  output logic                  overflow
);

  localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH + 1;
  localparam int unsigned SW = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  if (ACC_WIDTH < PW) begin : g_bad_acc_width
    $fatal(1, "ACC_WIDTH must be at least DIN0_WIDTH+DIN1_WIDTH+1");
  end
  if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_num_stage
    $fatal(1, "NUM_STAGE must be in 1..4");
  end

  logic                 en;
  logic                 sign0, sign1;
  logic [PW-1:0]        a_ext, b_ext;
  logic signed [PW-1:0] prod;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  assign sign0 = (DIN0_SIGNED != 0) && din0[DIN0_WIDTH-1];
  assign sign1 = (DIN1_SIGNED != 0) && din1[DIN1_WIDTH-1];
  assign a_ext = {{(PW-DIN0_WIDTH){sign0}}, din0};
  assign b_ext = {{(PW-DIN1_WIDTH){sign1}}, din1};
  // PW bits hold the exact product of the two narrower operands.
  assign prod  = $signed(a_ext) * $signed(b_ext);

  logic signed [PW-1:0] pipe_prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0] pipe_valid_q;
  logic [NUM_STAGE-1:0] pipe_last_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        pipe_prod_q[i] <= '0;
      end
      pipe_valid_q <= '0;
      pipe_last_q  <= '0;
    end else if (en) begin
      pipe_prod_q[0]  <= prod;
      pipe_valid_q[0] <= in_valid;
      pipe_last_q[0]  <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        pipe_prod_q[i]  <= pipe_prod_q[i-1];
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_last_q[i]  <= pipe_last_q[i-1];
      end
    end
  end

  logic [PW-1:0]        p_out;
  logic                 v_out, l_out;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 sticky_q;
  logic [SW-1:0]        sum_wide;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] sum_next;

  assign p_out = pipe_prod_q[NUM_STAGE-1];
  assign v_out = pipe_valid_q[NUM_STAGE-1];
  assign l_out = pipe_last_q[NUM_STAGE-1];

  // One guard bit: overflow whenever the top two bits of the widened sum disagree.
  assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {{(SW-PW){p_out[PW-1]}}, p_out};
  assign sum_ovf  = sum_wide[SW-1] ^ sum_wide[SW-2];

  always_comb begin
    sum_next = sum_wide[ACC_WIDTH-1:0];
    if (sum_ovf && (SATURATE != 0)) begin
      sum_next = sum_wide[SW-1] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q     <= '0;
      sticky_q  <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      overflow  <= 1'b0;
    end else begin
      if (v_out && en) begin
        if (l_out) begin
          dout      <= sum_next;
          overflow  <= sticky_q | sum_ovf;
          out_valid <= 1'b1;
          acc_q     <= '0;
          sticky_q  <= 1'b0;
        end else begin
          acc_q    <= sum_next;
          sticky_q <= sticky_q | sum_ovf;
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
